gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised memory-mapped GPIO peripheral for the SoC, replacing the fixed 8-bit output-only GPIO register with a bidirectional, configurable-width bank.
- Provides per-pin direction control and atomic set/clear/toggle writes.
- Synchronises pad inputs and raises a level interrupt on enabled rising/falling edges.
- Sits on the core's peripheral bus alongside the UART; pads are driven from the top level.

## Interface
- WIDTH, default 8: number of pins, legal range 1..32.
- SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
- RESET_OUT, default '0: reset value of DATA_OUT, WIDTH bits.
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, synchronous, active-high.
- bus_addr  input  6  byte address; bits [1:0] are ignored.
- bus_wdata  input  32  write data.
- bus_we  input  1  write strobe, one transfer per cycle.
- bus_re  input  1  read strobe.
- bus_rdata  output  32  registered read data.
- bus_rvalid  output  1  high for one cycle when bus_rdata is valid.
- gpio_in  input  WIDTH  asynchronous pad inputs.
- gpio_out  output  WIDTH  pad output values, equal to DATA_OUT.
- gpio_oe  output  WIDTH  pad output enables, equal to DIR; 1 = drive.
- irq  output  1  level interrupt, equal to the OR-reduction of IRQ_PEND.

## Operation
Register map (byte offsets):
- 0x00 DATA_OUT, RW.
- 0x04 DIR, RW.
- 0x08 DATA_IN, RO: synchronised gpio_in.
- 0x0C OUT_SET, WO: DATA_OUT |= wdata.
- 0x10 OUT_CLR, WO: DATA_OUT &= ~wdata.
- 0x14 OUT_TGL, WO: DATA_OUT ^= wdata.
- 0x18 RISE_EN, RW.
- 0x1C FALL_EN, RW.
- 0x20 IRQ_PEND, RW1C.

Access rules:
- Only bits [WIDTH-1:0] are stored. Upper bits read 0 and are ignored on write.
- WO registers read 0. Unmapped offsets read 0 and ignore writes.

Input path and edge detection:
- gpio_in passes through a SYNC_STAGES flop chain to form DATA_IN, then one further flop forms `prev`.
- rise[i] = DATA_IN[i] & ~prev[i]; fall[i] = ~DATA_IN[i] & prev[i].
- IRQ_PEND[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Edges are detected regardless of DIR, so output pins loop back.

Arming:
- A counter suppresses edge detection for SYNC_STAGES+1 cycles after rst deasserts, so pins held high through reset raise no spurious rise.
- States: ARMING (counter running), then ARMED (terminal). rst returns the block to ARMING.

## Timing
- Reset values:
  - DATA_OUT = RESET_OUT.
  - DIR, RISE_EN, FALL_EN, IRQ_PEND = 0.
  - Synchroniser flops and prev = 0.
  - bus_rdata = 0, bus_rvalid = 0, irq = 0, gpio_oe = 0, gpio_out = RESET_OUT.
- Reset mid-operation aborts any pending read: bus_rvalid is 0 in the cycle after rst.
- Writes take effect at the sampling edge and are visible on gpio_out, gpio_oe and readback from the next cycle.
- Reads: bus_re in cycle N gives bus_rdata and bus_rvalid in cycle N+1.
  - Read data reflects register state before any same-cycle write.
  - Simultaneous bus_re and bus_we are legal.
- Input latency:
  - A gpio_in change that is stable before edge N appears in DATA_IN after SYNC_STAGES edges.
  - IRQ_PEND sets on the following edge.
  - irq is combinational from IRQ_PEND, so it asserts in the same cycle as IRQ_PEND.
- An edge event and a W1C of the same bit in the same cycle: set wins, so the bit stays 1.
- Clearing an enable does not clear IRQ_PEND. An edge on a disabled pin is lost; it is not latched for later.
- SET, CLR and TGL are single-cycle read-modify-writes with no hazards. Back-to-back writes on consecutive cycles compose in order.

## Test plan
- Reset with RESET_OUT=8'hA5, gpio_in=8'hFF held high -> gpio_out=8'hA5, gpio_oe=0, irq=0.
  - Check that no IRQ_PEND bit sets across the arming window, even with RISE_EN written to 8'hFF during ARMING.
- Write DATA_OUT=0x0F, then OUT_SET 0x30, then OUT_CLR 0x03, then OUT_TGL 0xFF on consecutive cycles -> gpio_out=0x0F, 0x3F, 0x3C, 0xC3 on successive cycles.
  - Read of 0x0C returns 0 with rvalid one cycle after re.
- RISE_EN=0x01, FALL_EN=0x02, SYNC_STAGES=2.
  - Drive gpio_in[0] 0->1 at cycle T -> IRQ_PEND=0x01 and irq=1 at T+3.
  - Drive gpio_in[1] 1->0 -> bit 1 sets.
  - Write 0x03 to IRQ_PEND -> irq=0 next cycle.
- Collision: W1C of bit 0 in the same cycle a new rising edge is detected on pin 0 -> IRQ_PEND[0] remains 1.
- WIDTH=32: write 0xFFFF_FFFF to DIR -> reads back 0xFFFF_FFFF. WIDTH=5: the same write reads back 0x1F.
  - Read of unmapped offset 0x3C returns 0.
- Assert rst for one cycle with bus_re asserted the cycle before -> bus_rvalid=0 in the cycle after rst, all registers at reset values, arming restarts.

Source files
------------

// File: rtl/gpio_bank_if.sv
// Peripheral bus between the core and gpio_bank.
// Writes take effect in a single cycle; reads return one cycle after the strobe.
interface gpio_bank_if;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank with per-pin direction, set/clear/toggle writes,
// synchronised inputs and edge-triggered level interrupt.
module gpio_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             rst,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] W_DATA_OUT = 4'h0;
    localparam logic [3:0] W_DIR      = 4'h1;
    localparam logic [3:0] W_DATA_IN  = 4'h2;
    localparam logic [3:0] W_OUT_SET  = 4'h3;
    localparam logic [3:0] W_OUT_CLR  = 4'h4;
    localparam logic [3:0] W_OUT_TGL  = 4'h5;
    localparam logic [3:0] W_RISE_EN  = 4'h6;
    localparam logic [3:0] W_FALL_EN  = 4'h7;
    localparam logic [3:0] W_IRQ_PEND = 4'h8;

    typedef enum logic {ARMING, ARMED} arm_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;
    arm_e             arm_q;
    logic [1:0]       arm_cnt_q;

    logic [3:0]       word;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] rd_field;
    logic [31:0]      rd_val;
    logic             unused_bus;

    assign word       = bus.bus_addr[5:2];
    assign wdata      = bus.bus_wdata[WIDTH-1:0];
    assign unused_bus = ^{bus.bus_addr[1:0], bus.bus_wdata};
    assign data_in    = sync_q[SYNC_STAGES-1];

    assign edge_ev = (arm_q == ARMED)
                   ? ((data_in & ~prev_q & rise_en_q) | (~data_in & prev_q & fall_en_q))
                   : '0;

    always_comb begin
        rd_field = '0;
        case (word)
            W_DATA_OUT: rd_field = out_q;
            W_DIR:      rd_field = dir_q;
            W_DATA_IN:  rd_field = data_in;
            W_RISE_EN:  rd_field = rise_en_q;
            W_FALL_EN:  rd_field = fall_en_q;
            W_IRQ_PEND: rd_field = pend_q;
            default:    rd_field = '0;
        endcase
        rd_val               = '0;
        rd_val[WIDTH-1:0]    = rd_field;
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_d    = pend_q;
        if (bus.bus_we) begin
            case (word)
                W_DATA_OUT: out_d     = wdata;
                W_DIR:      dir_d     = wdata;
                W_OUT_SET:  out_d     = out_q | wdata;
                W_OUT_CLR:  out_d     = out_q & ~wdata;
                W_OUT_TGL:  out_d     = out_q ^ wdata;
                W_RISE_EN:  rise_en_d = wdata;
                W_FALL_EN:  fall_en_d = wdata;
                W_IRQ_PEND: pend_d    = pend_q & ~wdata;
                default:    ;
            endcase
        end
        // New edges are OR-ed in after the W1C so a colliding event survives.
        pend_d  = pend_d | edge_ev;
        rdata_d = bus.bus_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= data_in;
            rdata_q   <= rdata_d;
            rvalid_q  <= bus.bus_re;
            sync_q[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Hold off detection until the synchroniser and prev have flushed the reset zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q     <= ARMING;
            arm_cnt_q <= '0;
        end else begin
            case (arm_q)
                ARMING: begin
                    if (arm_cnt_q == 2'(SYNC_STAGES)) begin
                        arm_q <= ARMED;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 2'd1;
                    end
                end
                ARMED:   arm_q <= ARMED;
                default: arm_q <= ARMING;
            endcase
        end
    end

    assign gpio_out       = out_q;
    assign gpio_oe        = dir_q;
    assign irq            = |pend_q;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus random bus/pad
// traffic compared against a cycle-indexed behavioural model of the register map.
module tb_gpio_bank;

    localparam int SYNC = 2;
    localparam logic [7:0] RST_OUT = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        we, re;
    logic [7:0]  gin;

    logic [7:0]  gout8, goe8;
    logic [4:0]  gout5, goe5;
    logic [31:0] gout32, goe32;
    logic        irq8, irq5, irq32;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_bank_if ifc8 ();
    gpio_bank_if ifc5 ();
    gpio_bank_if ifc32 ();

    assign ifc8.bus_addr   = addr;  assign ifc5.bus_addr   = addr;  assign ifc32.bus_addr   = addr;
    assign ifc8.bus_wdata  = wdata; assign ifc5.bus_wdata  = wdata; assign ifc32.bus_wdata  = wdata;
    assign ifc8.bus_we     = we;    assign ifc5.bus_we     = we;    assign ifc32.bus_we     = we;
    assign ifc8.bus_re     = re;    assign ifc5.bus_re     = re;    assign ifc32.bus_re     = re;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(SYNC), .RESET_OUT(RST_OUT)) dut8 (
        .clk(clk), .rst(rst), .bus(ifc8), .gpio_in(gin),
        .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
    );

    gpio_bank #(.WIDTH(5), .SYNC_STAGES(2), .RESET_OUT(5'h00)) dut5 (
        .clk(clk), .rst(rst), .bus(ifc5), .gpio_in(gin[4:0]),
        .gpio_out(gout5), .gpio_oe(goe5), .irq(irq5)
    );

    gpio_bank #(.WIDTH(32), .SYNC_STAGES(3), .RESET_OUT(32'h0)) dut32 (
        .clk(clk), .rst(rst), .bus(ifc32), .gpio_in({24'h0, gin}),
        .gpio_out(gout32), .gpio_oe(goe32), .irq(irq32)
    );

    always #5 clk = ~clk;

    // Reference model for dut8: registers plus a log of pad samples per edge since reset.
    logic [7:0]  m_out, m_dir, m_rise, m_fall, m_pend;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    int          n_edge;
    logic [7:0]  in_log [4096];

    function automatic logic [7:0] din(input int k);
        return (k >= 1) ? in_log[k] : 8'h00;
    endfunction

    task automatic model_reset();
        m_out = RST_OUT; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_rdata = '0; m_rvalid = 1'b0; n_edge = 0;
    endtask

    task automatic model_step(input logic [5:0] a, input logic [31:0] wd,
                              input logic w, input logic r, input logic [7:0] g);
        logic [7:0] d, p, ev, rd;
        if (n_edge < 4095) n_edge++;
        in_log[n_edge] = g;
        d  = din(n_edge - SYNC);
        p  = din(n_edge - SYNC - 1);
        ev = (n_edge >= SYNC + 2) ? ((d & ~p & m_rise) | (~d & p & m_fall)) : 8'h00;
        case (a[5:2])
            4'd0: rd = m_out;
            4'd1: rd = m_dir;
            4'd2: rd = d;
            4'd6: rd = m_rise;
            4'd7: rd = m_fall;
            4'd8: rd = m_pend;
            default: rd = 8'h00;
        endcase
        if (r) m_rdata = {24'h0, rd};
        m_rvalid = r;
        if (w) begin
            case (a[5:2])
                4'd0: m_out  = wd[7:0];
                4'd1: m_dir  = wd[7:0];
                4'd3: m_out  = m_out | wd[7:0];
                4'd4: m_out  = m_out & ~wd[7:0];
                4'd5: m_out  = m_out ^ wd[7:0];
                4'd6: m_rise = wd[7:0];
                4'd7: m_fall = wd[7:0];
                4'd8: m_pend = m_pend & ~wd[7:0];
                default: ;
            endcase
        end
        m_pend = m_pend | ev;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("gpio_out", {24'h0, gout8}, {24'h0, m_out});
        check("gpio_oe", {24'h0, goe8}, {24'h0, m_dir});
        check("irq", {31'h0, irq8}, {31'h0, |m_pend});
        check("rvalid", {31'h0, ifc8.bus_rvalid}, {31'h0, m_rvalid});
        if (m_rvalid) check("rdata", ifc8.bus_rdata, m_rdata);
    endtask

    task automatic cycle(input logic [5:0] a, input logic [31:0] wd, input logic w, input logic r);
        @(negedge clk);
        rst = 1'b0; addr = a; wdata = wd; we = w; re = r;
        model_step(a, wd, w, r, gin);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(6'h00, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; we = 1'b0; re = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; gin = 8'hFF;
        do_reset();
        do_reset();
        check("rst_gpio_out", {24'h0, gout8}, 32'h0000_00A5);
        check("rst_gpio_oe", {24'h0, goe8}, 32'h0);
        check("rst_irq", {31'h0, irq8}, 32'h0);
        check("rst_rdata", ifc8.bus_rdata, 32'h0);

        // Pins held high through reset with rising edges enabled during arming.
        cycle(6'h18, 32'hFF, 1'b1, 1'b0);
        repeat (5) begin
            idle();
            check("arm_irq", {31'h0, irq8}, 32'h0);
        end
        cycle(6'h20, 32'h0, 1'b0, 1'b1);
        check("arm_pend", ifc8.bus_rdata, 32'h0);
        cycle(6'h18, 32'h0, 1'b1, 1'b0);

        // Back-to-back DATA_OUT / SET / CLR / TGL.
        cycle(6'h00, 32'h0F, 1'b1, 1'b0); check("seq_wr",  {24'h0, gout8}, 32'h0F);
        cycle(6'h0C, 32'h30, 1'b1, 1'b0); check("seq_set", {24'h0, gout8}, 32'h3F);
        cycle(6'h10, 32'h03, 1'b1, 1'b0); check("seq_clr", {24'h0, gout8}, 32'h3C);
        cycle(6'h14, 32'hFF, 1'b1, 1'b0); check("seq_tgl", {24'h0, gout8}, 32'hC3);
        cycle(6'h0C, 32'h0, 1'b0, 1'b1);
        check("wo_rvalid", {31'h0, ifc8.bus_rvalid}, 32'h1);
        check("wo_rdata", ifc8.bus_rdata, 32'h0);

        // Rise on pin 0, fall on pin 1.
        gin = 8'h02;
        cycle(6'h18, 32'h01, 1'b1, 1'b0);
        cycle(6'h1C, 32'h02, 1'b1, 1'b0);
        repeat (3) idle();
        cycle(6'h20, 32'hFF, 1'b1, 1'b0);
        check("pre_irq", {31'h0, irq8}, 32'h0);
        gin = 8'h03;
        idle();
        idle();
        check("rise_early", {31'h0, irq8}, 32'h0);
        idle();
        check("rise_irq", {31'h0, irq8}, 32'h1);
        cycle(6'h20, 32'h0, 1'b0, 1'b1);
        check("rise_pend", ifc8.bus_rdata, 32'h01);
        gin = 8'h01;
        repeat (3) idle();
        cycle(6'h20, 32'h0, 1'b0, 1'b1);
        check("fall_pend", ifc8.bus_rdata, 32'h03);
        cycle(6'h20, 32'h03, 1'b1, 1'b0);
        check("w1c_irq", {31'h0, irq8}, 32'h0);

        // W1C colliding with a fresh rising edge on pin 0.
        gin = 8'h00;
        repeat (4) idle();
        check("coll_pre", {31'h0, irq8}, 32'h0);
        gin = 8'h01;
        idle();
        idle();
        cycle(6'h20, 32'h01, 1'b1, 1'b0);
        check("coll_irq", {31'h0, irq8}, 32'h1);
        cycle(6'h20, 32'h0, 1'b0, 1'b1);
        check("coll_pend", ifc8.bus_rdata, 32'h01);

        // Width masking and unmapped offset on all three instances.
        cycle(6'h04, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle(6'h04, 32'h0, 1'b0, 1'b1);
        check("dir_w8", ifc8.bus_rdata, 32'h0000_00FF);
        check("dir_w5", ifc5.bus_rdata, 32'h0000_001F);
        check("dir_w32", ifc32.bus_rdata, 32'hFFFF_FFFF);
        cycle(6'h3C, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("unmap_w8", ifc8.bus_rdata, 32'h0);
        check("unmap_w5", ifc5.bus_rdata, 32'h0);
        check("unmap_w32", ifc32.bus_rdata, 32'h0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) gin = 8'($urandom);
            cycle(6'($urandom), $urandom, 1'($urandom), 1'($urandom));
        end

        // Reset with a read issued in the preceding cycle.
        gin = 8'hFF;
        cycle(6'h04, 32'h0, 1'b0, 1'b1);
        do_reset();
        check("mid_rvalid", {31'h0, ifc8.bus_rvalid}, 32'h0);
        check("mid_gpio_out", {24'h0, gout8}, 32'hA5);
        check("mid_gpio_oe", {24'h0, goe8}, 32'h0);
        check("mid_irq", {31'h0, irq8}, 32'h0);
        cycle(6'h18, 32'hFF, 1'b1, 1'b0);
        repeat (4) begin
            idle();
            check("rearm_irq", {31'h0, irq8}, 32'h0);
        end
        cycle(6'h04, 32'h0, 1'b0, 1'b1); check("mid_dir",  ifc8.bus_rdata, 32'h0);
        cycle(6'h1C, 32'h0, 1'b0, 1'b1); check("mid_fall", ifc8.bus_rdata, 32'h0);
        cycle(6'h20, 32'h0, 1'b0, 1'b1); check("mid_pend", ifc8.bus_rdata, 32'h0);
        cycle(6'h00, 32'h0, 1'b0, 1'b1); check("mid_dout", ifc8.bus_rdata, 32'hA5);
        cycle(6'h08, 32'h0, 1'b0, 1'b1); check("mid_din",  ifc8.bus_rdata, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
